tx_pcs_encoder: RTL and testbench

TX_PCS_ENCODER -- requirements
Module: tx_pcs_encoder

---
 rtl/tx_pcs_encoder.sv | 188 ++++++++++++++++++
 tb/tb_tx_pcs_encoder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/tx_pcs_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tx_pcs_encoder
// Description : Pairs two 32-bit XGMII beats into one 64b/66b block, with
//               pass-through backpressure and illegal-pattern error blocks.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_pcs_encoder #(
    parameter int XGMII_DATA_WIDTH = 32,
    parameter int XGMII_CTRL_WIDTH = 4
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic [XGMII_DATA_WIDTH-1:0] i_xgmii_txd,
    input  logic [XGMII_CTRL_WIDTH-1:0] i_xgmii_ctrl,
    input  logic                        i_xgmii_valid,
    output logic                        o_xgmii_pause,
    input  logic                        i_pcs_pause,
    output logic [65:0]                 o_block,
    output logic                        o_block_valid
);

    localparam logic [7:0] c_CH_IDLE    = 8'h07;
    localparam logic [7:0] c_CH_ERROR   = 8'hFE;
    localparam logic [7:0] c_CH_START   = 8'hFB;
    localparam logic [7:0] c_CH_TERM    = 8'hFD;

    localparam logic [6:0] c_CODE_IDLE  = 7'h00;
    localparam logic [6:0] c_CODE_ERROR = 7'h1E;

    localparam logic [1:0] c_SH_DATA    = 2'b10;
    localparam logic [1:0] c_SH_CTRL    = 2'b01;

    localparam logic [7:0] c_TYPE_CTRL  = 8'h1E;
    localparam logic [7:0] c_TYPE_S0    = 8'h78;
    localparam logic [7:0] c_TYPE_S4    = 8'h33;

    localparam logic [65:0] c_ERR_BLOCK = {{8{c_CODE_ERROR}}, c_TYPE_CTRL, c_SH_CTRL};

    // ------------------------------------------------------------------------
    // Beat acceptance and half-block capture
    // ------------------------------------------------------------------------
    logic                        r_phase;
    logic [XGMII_DATA_WIDTH-1:0] r_half_data;
    logic [XGMII_CTRL_WIDTH-1:0] r_half_ctrl;
    logic [65:0]                 r_block;
    logic                        r_block_valid;

    logic                        w_accept;
    logic [63:0]                 w_word;
    logic [7:0]                  w_ctrl;
    logic [65:0]                 w_next_block;

    assign o_xgmii_pause = i_pcs_pause;
    assign w_accept      = i_xgmii_valid && !i_pcs_pause;

    // The current beat is always the upper half when it completes a block.
    assign w_word = {i_xgmii_txd, r_half_data};
    assign w_ctrl = {i_xgmii_ctrl, r_half_ctrl};

    // ------------------------------------------------------------------------
    // Per-lane character decode
    // ------------------------------------------------------------------------
    logic [7:0][7:0] w_lane;
    logic [7:0]      w_is_idle;
    logic [7:0]      w_is_err;
    logic [7:0][6:0] w_code;

    assign w_lane = w_word;

    for (genvar n = 0; n < 8; n++) begin : g_lane
        assign w_is_idle[n] = w_ctrl[n] && (w_lane[n] == c_CH_IDLE);
        assign w_is_err[n]  = w_ctrl[n] && (w_lane[n] == c_CH_ERROR);
        assign w_code[n]    = w_is_idle[n] ? c_CODE_IDLE : c_CODE_ERROR;
    end

    // ------------------------------------------------------------------------
    // Block-format classification
    // ------------------------------------------------------------------------
    logic       w_all_data;
    logic       w_all_ctrl;
    logic       w_start0;
    logic       w_start4;
    logic [7:0] w_term_hit;

    assign w_all_data = (w_ctrl == 8'h00);
    assign w_all_ctrl = ((w_is_idle | w_is_err) == 8'hFF);
    assign w_start0   = (w_ctrl == 8'h01) && (w_lane[0] == c_CH_START);
    assign w_start4   = (w_ctrl == 8'h1F) && (w_is_idle[3:0] == 4'hF)
                        && (w_lane[4] == c_CH_START);

    // Terminate in lane k: data below, idles strictly above.
    for (genvar k = 0; k < 8; k++) begin : g_term
        localparam logic [7:0] c_CTRL_PAT = 8'(8'hFF << k);
        localparam logic [7:0] c_ABOVE    = 8'(8'hFE << k);
        assign w_term_hit[k] = (w_ctrl == c_CTRL_PAT)
                               && (w_lane[k] == c_CH_TERM)
                               && ((w_is_idle & c_ABOVE) == c_ABOVE);
    end

    // ------------------------------------------------------------------------
    // Terminate payload and type
    // ------------------------------------------------------------------------
    logic [2:0]  w_term_k;
    logic [7:0]  w_term_type;
    logic [55:0] w_term_payload;

    always_comb begin
        w_term_k = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_term_hit[i]) begin
                w_term_k = 3'(i);
            end
        end
    end

    always_comb begin
        w_term_type = 8'h87;
        case (w_term_k)
            3'd0:    w_term_type = 8'h87;
            3'd1:    w_term_type = 8'h99;
            3'd2:    w_term_type = 8'hAA;
            3'd3:    w_term_type = 8'hB4;
            3'd4:    w_term_type = 8'hCC;
            3'd5:    w_term_type = 8'hD2;
            3'd6:    w_term_type = 8'hE1;
            default: w_term_type = 8'hFF;
        endcase
    end

    // Idle codes after the terminate are all-zero, so only data octets land here.
    always_comb begin
        w_term_payload = '0;
        for (int i = 0; i < 7; i++) begin
            if (3'(i) < w_term_k) begin
                w_term_payload[8*i +: 8] = w_lane[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Block assembly
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_block = c_ERR_BLOCK;
        if (w_all_data) begin
            w_next_block = {w_word, c_SH_DATA};
        end else if (w_all_ctrl) begin
            w_next_block = {w_code, c_TYPE_CTRL, c_SH_CTRL};
        end else if (w_start0) begin
            w_next_block = {w_word[63:8], c_TYPE_S0, c_SH_CTRL};
        end else if (w_start4) begin
            w_next_block = {w_word[63:40], 4'h0, w_code[3:0], c_TYPE_S4, c_SH_CTRL};
        end else if (|w_term_hit) begin
            w_next_block = {w_term_payload, w_term_type, c_SH_CTRL};
        end
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_phase       <= 1'b0;
            r_half_data   <= '0;
            r_half_ctrl   <= '0;
            r_block       <= '0;
            r_block_valid <= 1'b0;
        end else begin
            r_block_valid <= 1'b0;
            if (w_accept) begin
                r_phase <= ~r_phase;
                if (!r_phase) begin
                    r_half_data <= i_xgmii_txd;
                    r_half_ctrl <= i_xgmii_ctrl;
                end else begin
                    r_block       <= w_next_block;
                    r_block_valid <= 1'b1;
                end
            end
        end
    end

    assign o_block       = r_block;
    assign o_block_valid = r_block_valid;

endmodule
`default_nettype wire

// File: tb/tb_tx_pcs_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_pcs_encoder
// Description : Directed self-checking bench for tx_pcs_encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_pcs_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] txd = '0;
    logic [3:0]  ctrl = '0;
    logic        valid = 1'b0;
    logic        pcs_pause = 1'b0;
    logic        xgmii_pause;
    logic [65:0] blk;
    logic        blk_valid;

    int total = 0;
    int bad   = 0;

    localparam logic [65:0] c_IDLE_BLK = 66'h079;
    localparam logic [65:0] c_ERR_BLK  = {{8{7'h1E}}, 8'h1E, 2'b01};

    tx_pcs_encoder #(
        .XGMII_DATA_WIDTH(32),
        .XGMII_CTRL_WIDTH(4)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_xgmii_txd  (txd),
        .i_xgmii_ctrl (ctrl),
        .i_xgmii_valid(valid),
        .o_xgmii_pause(xgmii_pause),
        .i_pcs_pause  (pcs_pause),
        .o_block      (blk),
        .o_block_valid(blk_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one beat for exactly one rising edge; returns 1 time unit after it.
    task automatic beat(input logic [31:0] d, input logic [3:0] c);
        @(negedge clk);
        txd   = d;
        ctrl  = c;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic pair(input string tag, input logic [31:0] d0, input logic [3:0] c0,
                        input logic [31:0] d1, input logic [3:0] c1,
                        input logic [65:0] exp);
        beat(d0, c0);
        chk({tag, "_half_novalid"}, {65'h0, blk_valid}, 66'h0);
        beat(d1, c1);
        chk({tag, "_valid"}, {65'h0, blk_valid}, 66'h1);
        chk({tag, "_block"}, blk, exp);
    endtask

    initial begin
        // Reset with a beat offered; it must be ignored.
        valid = 1'b1;
        txd   = 32'hDEADBEEF;
        ctrl  = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", {65'h0, blk_valid}, 66'h0);
        chk("reset_block", blk, 66'h0);
        @(negedge clk);
        rst   = 1'b0;
        valid = 1'b0;

        pair("idle_pair", 32'h07070707, 4'hF, 32'h07070707, 4'hF, c_IDLE_BLK);
        @(posedge clk);
        #1;
        chk("valid_one_cycle", {65'h0, blk_valid}, 66'h0);
        chk("block_held", blk, c_IDLE_BLK);

        pair("start0", 32'h555555FB, 4'h1, 32'hD5555555, 4'h0,
             {56'hD5_5555_5555_5555, 8'h78, 2'b01});
        pair("term3", 32'hFD332211, 4'h8, 32'h07070707, 4'hF,
             {32'h0, 24'h332211, 8'hB4, 2'b01});
        pair("term0", 32'h070707FD, 4'hF, 32'h07070707, 4'hF,
             {56'h0, 8'h87, 2'b01});
        pair("term7", 32'h33221100, 4'h0, 32'hFD665544, 4'h8,
             {56'h66_5544_3322_1100, 8'hFF, 2'b01});
        pair("idle_err_mix", 32'h07FE0707, 4'hF, 32'h07070707, 4'hF,
             {56'h00_0000_0007_8000, 8'h1E, 2'b01});
        pair("start4", 32'h07070707, 4'hF, 32'hAABBCCFB, 4'h1,
             {24'hAABBCC, 4'h0, 28'h0, 8'h33, 2'b01});

        // Data block with an idle (valid=0) cycle between the halves.
        beat(32'h03020100, 4'h0);
        @(posedge clk);
        #1;
        chk("gap_novalid", {65'h0, blk_valid}, 66'h0);
        beat(32'h07060504, 4'h0);
        chk("data_valid", {65'h0, blk_valid}, 66'h1);
        chk("data_block", blk, {64'h0706050403020100, 2'b10});

        // Backpressure between halves.
        beat(32'hAABBCCDD, 4'h0);
        @(negedge clk);
        pcs_pause = 1'b1;
        txd       = 32'h11111111;
        ctrl      = 4'hF;
        valid     = 1'b1;
        #1;
        chk("pause_passthru_hi", {65'h0, xgmii_pause}, 66'h1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("pause_novalid", {65'h0, blk_valid}, 66'h0);
        end
        @(negedge clk);
        pcs_pause = 1'b0;
        txd       = 32'h44332211;
        ctrl      = 4'h0;
        #1;
        chk("pause_passthru_lo", {65'h0, xgmii_pause}, 66'h0);
        @(posedge clk);
        #1;
        valid = 1'b0;
        chk("pause_resume_valid", {65'h0, blk_valid}, 66'h1);
        chk("pause_resume_block", blk, {64'h44332211AABBCCDD, 2'b10});

        // Illegal start position, then normal encoding recovers.
        pair("start_lane2", 32'h55FB5555, 4'h4, 32'h55555555, 4'h0, c_ERR_BLK);
        pair("after_error", 32'h07070707, 4'hF, 32'h07070707, 4'hF, c_IDLE_BLK);
        pair("term_nonidle_after", 32'h0707FD11, 4'hE, 32'h07070755, 4'hE, c_ERR_BLK);

        // Reset between halves discards the captured half.
        beat(32'h12345678, 4'h0);
        @(negedge clk);
        rst   = 1'b1;
        valid = 1'b1;
        txd   = 32'h9ABCDEF0;
        ctrl  = 4'h0;
        @(posedge clk);
        #1;
        chk("midreset_valid", {65'h0, blk_valid}, 66'h0);
        chk("midreset_block", blk, 66'h0);
        @(negedge clk);
        rst   = 1'b0;
        valid = 1'b0;
        pair("post_reset_idle", 32'h07070707, 4'hF, 32'h07070707, 4'hF, c_IDLE_BLK);
        @(posedge clk);
        #1;
        chk("post_reset_single", {65'h0, blk_valid}, 66'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
